// File: rtl/jtdd2_mcu_ctrl_if.sv
// rtl/jtdd2_mcu_ctrl_if.sv - main-CPU bus and sub-CPU handshake signals of the DD2 MCU controller
interface jtdd2_mcu_ctrl_if;
  logic       cen;
  logic       ctrl_cs;
  logic       com_cs;
  logic       main_wrn;
  logic [7:0] main_dout;
  logic       irq_ack;
  logic       mcu_ban;
  logic       mcu_irqmain;
  logic       mcu_halt;
  logic       mcu_nmi_set;
  logic       main_irq;
  logic       main_wait;
  logic [7:0] status_dout;

  modport master (
    output cen, ctrl_cs, com_cs, main_wrn, main_dout, irq_ack, mcu_ban, mcu_irqmain,
    input  mcu_halt, mcu_nmi_set, main_irq, main_wait, status_dout
  );

  modport slave (
    input  cen, ctrl_cs, com_cs, main_wrn, main_dout, irq_ack, mcu_ban, mcu_irqmain,
    output mcu_halt, mcu_nmi_set, main_irq, main_wait, status_dout
  );
endinterface

// File: rtl/jtdd2_mcu_ctrl.sv
// rtl/jtdd2_mcu_ctrl.sv - DD2 sub-CPU halt/NMI/IRQ controller on the main CPU side
// Optional JTDD2_MCU_AUTOHALT_EN: shared-RAM accesses request the bus and stall until granted.
module jtdd2_mcu_ctrl #(
  parameter int NMI_LEN = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  jtdd2_mcu_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int NW = $clog2(NMI_LEN + 1);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HALT_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;
  localparam logic [1:0] ST_RELEASE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          halt_req_q, halt_req_d;
  logic          mcu_halt_q, mcu_halt_d;
  logic [NW-1:0] nmi_cnt_q, nmi_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          tmo_q, tmo_d;
  logic          wr_done_q, wr_done_d;
  logic          irqmain_q, irqmain_d;
  logic          irq_pend_q, irq_pend_d;
  logic          auto_req_q, auto_req_d;
  logic          ctrl_wr, req, halted, wait_expired, irq_edge;

  // wr_done blocks repeated writes while main_wrn stays low across several cen pulses
  always_comb begin
    ctrl_wr    = bus.ctrl_cs & bus.cen & ~bus.main_wrn & ~wr_done_q;
    wr_done_d  = bus.main_wrn ? 1'b0 : (wr_done_q | ctrl_wr);
    halt_req_d = ctrl_wr ? bus.main_dout[0] : halt_req_q;

    nmi_cnt_d = nmi_cnt_q;
    if (ctrl_wr && bus.main_dout[1]) begin
      nmi_cnt_d = NW'(NMI_LEN);
    end else if (nmi_cnt_q != '0) begin
      nmi_cnt_d = nmi_cnt_q - NW'(1);
    end

`ifdef JTDD2_MCU_AUTOHALT_EN
    auto_req_d = bus.com_cs & (auto_req_q | (state_q == ST_RUN));
`else
    auto_req_d = 1'b0;
`endif
    req = halt_req_q | auto_req_q;

    state_d = state_q;
    case (state_q)
      ST_RUN:       if (req) state_d = ST_HALT_WAIT;
      ST_HALT_WAIT: begin
        if (!bus.mcu_ban)  state_d = ST_HALTED;
        else if (!req)     state_d = ST_RELEASE;
      end
      ST_HALTED:    if (!req) state_d = ST_RELEASE;
      default: begin
        if (bus.mcu_ban)   state_d = ST_RUN;
        else if (req)      state_d = ST_HALT_WAIT;
      end
    endcase

    // the counter saturates one past the threshold so the flag fires once per wait
    wait_cnt_d = '0;
    if (state_q == ST_HALT_WAIT) begin
      wait_cnt_d = (wait_cnt_q == CW'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end
    wait_expired = (state_q == ST_HALT_WAIT) && (wait_cnt_q == CW'(TIMEOUT - 1));
    tmo_d        = (tmo_q & ~ctrl_wr) | wait_expired;

    mcu_halt_d = (state_q == ST_HALT_WAIT) | (state_q == ST_HALTED);

    irqmain_d  = bus.mcu_irqmain;
    irq_edge   = bus.mcu_irqmain & ~irqmain_q;
    irq_pend_d = irq_edge ? 1'b1 : (bus.irq_ack ? 1'b0 : irq_pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      halt_req_q <= 1'b0;
      mcu_halt_q <= 1'b0;
      nmi_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
      wr_done_q  <= 1'b0;
      irqmain_q  <= 1'b0;
      irq_pend_q <= 1'b0;
      auto_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      halt_req_q <= halt_req_d;
      mcu_halt_q <= mcu_halt_d;
      nmi_cnt_q  <= nmi_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_d;
      wr_done_q  <= wr_done_d;
      irqmain_q  <= irqmain_d;
      irq_pend_q <= irq_pend_d;
      auto_req_q <= auto_req_d;
    end
  end

  assign halted          = (state_q == ST_HALTED);
  assign bus.mcu_halt    = mcu_halt_q;
  assign bus.mcu_nmi_set = (nmi_cnt_q != '0);
  assign bus.main_irq    = irq_pend_q;
  assign bus.status_dout = {4'b0, tmo_q, irq_pend_q, halted, halt_req_q};
`ifdef JTDD2_MCU_AUTOHALT_EN
  assign bus.main_wait   = bus.com_cs & ~halted;
`else
  assign bus.main_wait   = 1'b0;
`endif
endmodule
